// File: rtl/decim_scheduler.sv
// -----------------------------------------------------------------------------
// decim_scheduler
//
// Shares one decimation datapath among NUM_CH sample sources. A round-robin
// arbiter grants at most one requesting channel per cycle and accepts its
// sample. Each channel keeps a phase counter against the decimation ratio R.
// Every R-th accepted sample of a channel is forwarded on data_out, tagged
// with its channel number. Ratio changes are staged in a pending register.
// They are committed during a single quiet HALT cycle in which no grant is
// made, and all phase counters restart from zero at that point.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   [NUM_CH]     per-channel request, held until own ack
//   data_in    in   [NUM_CH*DW]  channel i sample at [i*DW +: DW]
//   ack        out  [NUM_CH]     one-hot, one-cycle accept pulse
//   cfg_we     in   write strobe for cfg_ratio
//   cfg_ratio  in   [RW]         requested ratio (0 behaves as 1)
//   data_out   out  [DW]         decimated sample
//   ch_out     out  [clog2]      channel of data_out
//   valid_out  out  qualifier for data_out / ch_out
//   busy       out  ratio change pending or being applied
// -----------------------------------------------------------------------------
module decim_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16,
  parameter int RW     = 3
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*DW-1:0]       data_in,
  output logic [NUM_CH-1:0]          ack,
  input  logic                       cfg_we,
  input  logic [RW-1:0]              cfg_ratio,
  output logic [DW-1:0]              data_out,
  output logic [$clog2(NUM_CH)-1:0]  ch_out,
  output logic                       valid_out,
  output logic                       busy
);

  localparam int CW = $clog2(NUM_CH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [RW-1:0] RATIO_RST = RW'(2);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Effective ratio: a programmed ratio of zero behaves as one.
  function automatic logic [RW-1:0] eff_ratio(input logic [RW-1:0] r);
    return (r == '0) ? RW'(1) : r;
  endfunction

  // Round-robin pick: first eligible channel at or after ptr, wrapping.
  // Returns {found, index}. Offsets are scanned from farthest to nearest so
  // the nearest eligible channel is the one left in the result.
  function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                          input logic [CW-1:0]     ptr);
    logic [CW:0]   res;
    logic [CW-1:0] sel;
    int            idx;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = CW'(idx);
      if (elig[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  // Pointer advance modulo NUM_CH (NUM_CH need not be a power of two).
  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] g);
    return (g == CW'(NUM_CH - 1)) ? '0 : g + CW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [CW-1:0]     r_ptr;
  logic [RW-1:0]     r_ratio;
  logic [RW-1:0]     r_pend_ratio;
  logic              r_pend;
  logic [RW-1:0]     r_phase [NUM_CH];
  logic [NUM_CH-1:0] r_ack;
  logic [DW-1:0]     r_data;
  logic [CW-1:0]     r_ch;
  logic              r_valid;

  logic [NUM_CH-1:0] w_elig;
  logic [CW:0]       w_pick;
  logic              w_gnt_vld;
  logic [CW-1:0]     w_gnt;
  logic [RW-1:0]     w_last_phase;
  logic              w_emit;
  logic [DW-1:0]     w_samp [NUM_CH];

  // Unpack the flat sample bus into one word per channel.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_samp[gi] = data_in[gi*DW +: DW];
  end

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, from registered ack and ptr)
  // ---------------------------------------------------------------------------
  // The channel acked in the current cycle is masked out: its req may still
  // be high for one cycle while the requester reacts, and it must not be
  // granted twice for the same sample.
  assign w_elig       = req & ~r_ack;
  assign w_pick       = rr_pick(w_elig, r_ptr);
  assign w_gnt_vld    = w_pick[CW];
  assign w_gnt        = w_pick[CW-1:0];
  assign w_last_phase = eff_ratio(r_ratio) - RW'(1);
  assign w_emit       = (r_phase[w_gnt] == w_last_phase);

  // ---------------------------------------------------------------------------
  // Registered stage: grant, accept, decimate, config commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_ptr        <= '0;
      r_ratio      <= RATIO_RST;
      r_pend_ratio <= '0;
      r_pend       <= 1'b0;
      r_ack        <= '0;
      r_data       <= '0;
      r_ch         <= '0;
      r_valid      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_gnt_vld) begin
            r_ack <= NUM_CH'(1) << w_gnt;
            r_ptr <= next_ptr(w_gnt);
            if (w_emit) begin
              r_data           <= w_samp[w_gnt];
              r_ch             <= w_gnt;
              r_valid          <= 1'b1;
              r_phase[w_gnt]   <= '0;
            end else begin
              r_phase[w_gnt]   <= r_phase[w_gnt] + RW'(1);
              r_valid          <= 1'b0;
            end
          end else begin
            r_ack   <= '0;
            r_valid <= 1'b0;
          end

          // A pending ratio (already registered) diverts to HALT; a write
          // arriving now only stages and halts on the following cycle.
          if (r_pend) r_state <= ST_HALT;
          if (cfg_we) begin
            r_pend_ratio <= cfg_ratio;
            r_pend       <= 1'b1;
          end
        end

        default: begin
          // Single quiet cycle: no grant, commit ratio, restart phases.
          // A write landing in this very cycle wins over the staged value.
          r_ack   <= '0;
          r_valid <= 1'b0;
          r_ratio <= cfg_we ? cfg_ratio : r_pend_ratio;
          r_pend  <= 1'b0;
          r_state <= ST_RUN;
          for (int i = 0; i < NUM_CH; i++) r_phase[i] <= '0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign data_out  = r_data;
  assign ch_out    = r_ch;
  assign valid_out = r_valid;
  assign busy      = r_pend | (r_state == ST_HALT);

endmodule

// File: tb/tb_decim_scheduler.sv
// -----------------------------------------------------------------------------
// tb_decim_scheduler
//
// Bench for decim_scheduler (NUM_CH=4, DW=16, RW=3). Requesters follow the
// hold-until-ack protocol and advance their sample after each ack. A
// behavioural model predicts every output each cycle. Directed scenarios add
// literal expectations for grant order, emitted samples and config timing.
// -----------------------------------------------------------------------------
module tb_decim_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int RW  = 3;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    ack;
  logic              cfg_we;
  logic [RW-1:0]     cfg_ratio;
  logic [DW-1:0]     data_out;
  logic [1:0]        ch_out;
  logic              valid_out;
  logic              busy;

  decim_scheduler #(.NUM_CH(NCH), .DW(DW), .RW(RW)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .cfg_we    (cfg_we),
    .cfg_ratio (cfg_ratio),
    .data_out  (data_out),
    .ch_out    (ch_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_ptr, m_ratio, m_pratio;
  int         m_phase [NCH];
  bit         m_pend, m_halt;
  logic [3:0] m_ack;
  logic       m_vld;
  logic [1:0] m_ch;
  logic [15:0] m_dout;

  task automatic model_reset();
    m_ptr = 0; m_ratio = 2; m_pratio = 0; m_pend = 0; m_halt = 0;
    m_ack = '0; m_vld = 0; m_ch = '0; m_dout = '0;
    for (int i = 0; i < NCH; i++) m_phase[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] elig;
    int g, c, reff;
    elig = req & ~m_ack;
    if (m_halt) begin
      m_ack = '0; m_vld = 0;
      m_ratio = cfg_we ? int'(cfg_ratio) : m_pratio;
      for (int i = 0; i < NCH; i++) m_phase[i] = 0;
      m_pend = 0; m_halt = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && ((elig >> c) & 4'd1) != 0) g = c;
      end
      if (g >= 0) begin
        m_ack = 4'(1 << g);
        m_ptr = (g + 1) % NCH;
        reff  = (m_ratio == 0) ? 1 : m_ratio;
        if (m_phase[g] == reff - 1) begin
          m_dout = 16'(data_in >> (g * DW));
          m_ch   = 2'(g);
          m_vld  = 1;
          m_phase[g] = 0;
        end else begin
          m_phase[g] = m_phase[g] + 1;
          m_vld = 0;
        end
      end else begin
        m_ack = '0; m_vld = 0;
      end
      m_halt = m_pend;
      if (cfg_we) begin m_pend = 1; m_pratio = int'(cfg_ratio); end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK_50 or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus state and logs
  // ---------------------------------------------------------------------------
  int         seq [NCH];
  logic [3:0] act;
  int         hold_pct, rise_pct, cfg_pct;
  int         pc [NCH];
  int         pc_chk;
  bit         r1_chk;
  int         g_log[$];
  int         a0_cyc[$];
  int         e_ch[$];
  int         e_dat[$];

  task automatic drive_data();
    for (int i = 0; i < NCH; i++) data_in[i*DW +: DW] = 16'(i * 4096 + seq[i]);
  endtask

  task automatic clear_logs();
    g_log.delete(); a0_cyc.delete(); e_ch.delete(); e_dat.delete();
  endtask

  // One clock: compare at the falling edge, log, then drive next inputs.
  task automatic cycle();
    @(negedge CLOCK_50);
    cyc++;
    chk("outputs", {8'h0, ack, valid_out, busy, ch_out, data_out},
                   {8'h0, m_ack, m_vld, (m_pend | m_halt), m_ch, m_dout});
    for (int i = 0; i < NCH; i++) begin
      if (ack[i]) begin
        g_log.push_back(i);
        if (i == 0) a0_cyc.push_back(cyc);
        pc[i]++;
      end
    end
    if (valid_out) begin
      e_ch.push_back(int'(ch_out));
      e_dat.push_back(int'(data_out));
      if (pc_chk > 0) chk("phase_rule", 32'(pc[ch_out] % pc_chk), 0);
    end
    if (r1_chk) chk("ratio1_valid", {31'h0, valid_out}, {31'h0, |ack});

    cfg_we = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ack[i]) begin
        seq[i]++;
        req[i] = act[i] && ($urandom_range(99) < hold_pct);
      end else if (!req[i]) begin
        req[i] = act[i] && ($urandom_range(99) < rise_pct);
      end
    end
    drive_data();
    if (cfg_pct > 0 && $urandom_range(99) < cfg_pct) begin
      cfg_we    = 1'b1;
      cfg_ratio = RW'($urandom_range(7));
    end
  endtask

  // Reset at the current time; outputs must clear without waiting for a clock.
  task automatic do_reset();
    act = '0; cfg_pct = 0;
    reset = 1'b1;
    #1;
    chk("async_reset", {8'h0, ack, valid_out, busy, ch_out, data_out}, 32'h0);
    req = '0; cfg_we = 1'b0;
    for (int i = 0; i < NCH; i++) begin seq[i] = 1; pc[i] = 0; end
    drive_data();
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_cfg(input logic [RW-1:0] r);
    cfg_we = 1'b1; cfg_ratio = r;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int cnt02;
    bit found;
    reset = 1'b1; req = '0; cfg_we = 1'b0; cfg_ratio = '0;
    act = '0; hold_pct = 100; rise_pct = 100; cfg_pct = 0;
    pc_chk = 0; r1_chk = 0;
    for (int i = 0; i < NCH; i++) begin seq[i] = 1; pc[i] = 0; end
    drive_data();
    run(2);
    chk("reset_state", {8'h0, ack, valid_out, busy, ch_out, data_out}, 32'h0);
    reset = 1'b0;

    // Channel 0 alone, ratio 2: samples 2,4,6 emitted, ack every other cycle.
    clear_logs(); act = 4'b0001; hold_pct = 100; rise_pct = 100;
    run(14);
    chk("s1_emit0", e_dat[0], 2);
    chk("s1_emit1", e_dat[1], 4);
    chk("s1_emit2", e_dat[2], 6);
    chk("s1_ch", e_ch[0] + e_ch[1] + e_ch[2], 0);
    chk("s1_ack_gap", a0_cyc[1] - a0_cyc[0], 2);

    // All four from reset: 0,1,2,3,0,1,2,3; second round emits 2nd samples.
    do_reset(); clear_logs(); act = 4'b1111;
    run(11);
    for (int i = 0; i < 8; i++) chk("s2_grant", g_log[i], i % 4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_emit_ch", e_ch[i], i);
      chk("s2_emit_dat", e_dat[i], i * 4096 + 2);
    end

    // Channels 1 and 3 only: 1,3,1,3 with the pointer wrapping 3 -> 0.
    do_reset(); clear_logs(); act = 4'b1010;
    run(10);
    for (int i = 0; i < 4; i++) chk("s3_grant", g_log[i], (i % 2 == 0) ? 1 : 3);
    cnt02 = 0;
    foreach (g_log[i]) if (g_log[i] == 0 || g_log[i] == 2) cnt02++;
    chk("s3_no_ch02", cnt02, 0);

    // Mid-stream ratio 3: busy two cycles, one ack-free cycle, then every
    // emission lands on a multiple of 3 accepts since the commit.
    do_reset(); act = 4'b1111; hold_pct = 70; rise_pct = 60;
    run(15);
    pulse_cfg(3'd3);
    cycle(); chk("s4_busy_k1", {31'h0, busy}, 1);
    cycle(); chk("s4_busy_k2", {31'h0, busy}, 1);
    for (int i = 0; i < NCH; i++) pc[i] = 0;
    cycle(); chk("s4_busy_k3", {31'h0, busy}, 0);
    chk("s4_halt_noack", {28'h0, ack}, 0);
    pc_chk = 3;
    run(60);
    pc_chk = 0;

    // Ratio 0 behaves as 1: every ack carries a valid sample.
    pulse_cfg(3'd0);
    run(3);
    r1_chk = 1;
    run(40);
    r1_chk = 0;

    // Reset while ch2 is acked with a valid sample in flight.
    do_reset(); act = 4'b1111; hold_pct = 100; rise_pct = 100;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (ack[2] && valid_out) found = 1;
    end
    chk("s6_wait_ack2", {31'h0, found}, 1);
    do_reset(); clear_logs(); act = 4'b0001;
    run(8);
    chk("s6_first_emit", e_dat[0], 2);
    chk("s6_first_emit_ch", e_ch[0], 0);

    // Random traffic with random config writes (including writes that land
    // in the commit cycle) and occasional resets.
    act = 4'b1111; hold_pct = 60; rise_pct = 50; cfg_pct = 8;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if ($urandom_range(199) == 0) begin
        do_reset();
        act = 4'($urandom_range(15)); hold_pct = 60; rise_pct = 50; cfg_pct = 8;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decim_scheduler.md
# decim_scheduler

Round-robin scheduler that shares one decimation datapath among NUM_CH 16-bit sample sources in the audio path. It arbitrates source requests, accepts one sample per grant, and keeps a per-channel phase counter against a programmable decimation ratio. It emits every R-th accepted sample of each channel, tagged with its channel number. It also owns the ratio configuration and applies new ratios only at a safe, quiesced cycle.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DW, 16, sample width
- RW, 3, decimation-ratio width

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clock CLOCK_50
- req  in  NUM_CH  per-channel sample request; held with stable data until own ack seen
- data_in  in  NUM_CH*DW  channel i sample at bits [i*DW +: DW]
- ack  out  NUM_CH  one-hot one-cycle accept pulse
- cfg_we  in  1  one-cycle write strobe for cfg_ratio
- cfg_ratio  in  RW  requested decimation ratio R; 0 treated as 1
- data_out  out  DW  decimated sample
- ch_out  out  clog2(NUM_CH)  channel of data_out
- valid_out  out  1  one-cycle qualifier for data_out/ch_out
- busy  out  1  config pending or being applied

## Operation
- Reset values: ack=0, data_out=0, ch_out=0, valid_out=0, busy=0, ratio=2, all phase[i]=0, ptr=0, pend=0, state=RUN.
- Eligible set = req & ~ack. The channel acked this cycle is masked, so a requester dropping req on the edge after ack is never double-granted.
- RUN: if the eligible set is non-empty, grant the first eligible channel at or after ptr (wrapping modulo NUM_CH). On that edge:
  - ack[g]<=1, ptr<=(g+1) mod NUM_CH.
  - Capture data_in[g]. If phase[g]==Reff-1 (Reff = ratio, or 1 when ratio==0): data_out<=sample, ch_out<=g, valid_out<=1, phase[g]<=0.
  - Otherwise phase[g]<=phase[g]+1 and valid_out<=0; data_out/ch_out hold.
- With no grant: ack<=0, valid_out<=0, ptr holds.
- Config:
  - cfg_we latches cfg_ratio into pend_ratio and sets pend.
  - RUN with pend set (registered) -> HALT.
- HALT (exactly one cycle):
  - No grant: ack=0, valid_out=0 on exit.
  - ratio<=pend_ratio, all phase<=0, pend<=0 -> RUN.
  - If cfg_we is asserted in the HALT cycle, cfg_ratio (input) is applied directly and pend stays 0.
- busy = pend | (state==HALT).
- cfg_we while the grant logic is active in RUN does not cancel that cycle's grant; the halt follows on the next cycle.
- Phase counters are RW bits wide; phase never exceeds Reff-1.

## Timing
- Accept latency: req high (and eligible) before edge k -> ack[i] and any valid_out high for the cycle after edge k, low after edge k+1 unless regranted.
- Max one grant per cycle. A single continuously requesting channel is granted every other cycle, because of ack masking.
- Config latency: cfg_we at edge k -> busy high after k, HALT during cycle k+1..k+2, new ratio in effect for grants from edge k+2. busy is low after k+2.
- Reset mid-operation clears all outputs immediately (asynchronous) regardless of state and restores ratio=2. An ack pulse in flight is lost; the requester re-requests.

## Test plan
- Ch0 only, req held, data 1,2,3,... advancing on each ack, ratio 2 -> valid_out with data 2,4,6, ch 0; ack every other cycle.
- All 4 req from reset, ratio 2 -> grants 0,1,2,3,0,1,2,3. First round no valid; second round valid with ch_out 0,1,2,3 carrying each channel's 2nd sample.
- req on ch1 and ch3 only -> grant order 1,3,1,3; ch0/ch2 never acked; ptr wraps 3->0 correctly.
- Mid-stream cfg_we with cfg_ratio=3 -> busy for 2 cycles, one cycle with no ack. Phases cleared; each channel then emits its 3rd, 6th, ... post-config sample.
- cfg_ratio=0 -> every accepted sample produces valid_out the same cycle as its ack.
- Reset asserted while ack[2]=1 and valid_out=1 -> ack, valid_out, data_out, ch_out 0 immediately. After release, ch0 requires 2 accepts before first valid.
